// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants, pixel record and state encoding for the framebuffer writer
package fb_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int FB_WORDS  = SCREEN_W * SCREEN_H;
  localparam int COLOUR_W  = 9;
  localparam int FB_ADDR_W = 15;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } fb_state_t;

  // 160 = 128 + 32, so the default geometry needs only two shifts and adds.
  function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y,
                                                    input int             width);
    logic [FB_ADDR_W-1:0] xa;
    logic [FB_ADDR_W-1:0] ya;
    xa = FB_ADDR_W'(x);
    ya = FB_ADDR_W'(y);
    if (width == 160) begin
      return (ya << 7) + (ya << 5) + xa;
    end
    return FB_ADDR_W'(int'(y) * width + int'(x));
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - power-of-two pixel queue with registered occupancy count
module pixel_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   push,
  input  pixel_t push_data,
  input  logic   pop,
  output pixel_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pixel_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count_q;
  logic               do_push;
  logic               do_pop;

  assign full     = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pixel_fb_writer.sv
// rtl/pixel_fb_writer.sv - buffers pixels, writes them to the framebuffer, and runs full-screen clears
module pixel_fb_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = fb_pkg::SCREEN_W,
  parameter int SCREEN_H   = fb_pkg::SCREEN_H
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_x,
  input  logic [6:0]  pix_y,
  input  logic [8:0]  pix_colour,
  input  logic        clear_req,
  input  logic [8:0]  clear_colour,
  output logic        busy,
  output logic [14:0] fb_addr,
  output logic [8:0]  fb_data,
  output logic        fb_wren,
  output logic [7:0]  drop_count
);

  import fb_pkg::pixel_t;
  import fb_pkg::fb_state_t;
  import fb_pkg::IDLE;
  import fb_pkg::DRAIN;
  import fb_pkg::CLEAR;
  import fb_pkg::FB_ADDR_W;
  import fb_pkg::COLOUR_W;
  import fb_pkg::pix_addr;

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(SCREEN_W * SCREEN_H - 1);

  fb_state_t             state_q;
  fb_state_t             state_d;
  logic                  rdy_q;
  logic [FB_ADDR_W-1:0]  clear_addr_q;
  logic [COLOUR_W-1:0]   clear_colour_q;
  pixel_t                in_pix;
  pixel_t                head;
  logic                  accept;
  logic                  on_screen;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign in_pix    = {pix_x, pix_y, pix_colour};
  assign on_screen = (int'(pix_x) < SCREEN_W) && (int'(pix_y) < SCREEN_H);
  // rdy_q keeps pix_ready low during reset and for the first edge after release.
  assign pix_ready = rdy_q && (state_q == IDLE) && !fifo_full;
  assign accept    = pix_valid && pix_ready;
  assign push      = accept && on_screen;
  assign drop      = accept && !on_screen;
  assign pop       = !fifo_empty && ((state_q == IDLE) || (state_q == DRAIN));
  assign busy      = (state_q != IDLE);

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (in_pix),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Every pop lands in the write stage on the same edge, so an empty FIFO
  // means nothing is left outstanding before the clear sweep starts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_req) state_d = DRAIN;
      DRAIN:   if (fifo_empty) state_d = CLEAR;
      CLEAR:   if (clear_addr_q == LAST_ADDR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      rdy_q          <= 1'b0;
      clear_addr_q   <= '0;
      clear_colour_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      if ((state_q == IDLE) && clear_req) begin
        clear_colour_q <= clear_colour;
      end
      if (state_q == CLEAR) begin
        clear_addr_q <= clear_addr_q + 1'b1;
      end else begin
        clear_addr_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fb_addr <= '0;
      fb_data <= '0;
      fb_wren <= 1'b0;
    end else if (pop) begin
      fb_addr <= pix_addr(head.x, head.y, SCREEN_W);
      fb_data <= head.colour;
      fb_wren <= 1'b1;
    end else if (state_q == CLEAR) begin
      fb_addr <= clear_addr_q;
      fb_data <= clear_colour_q;
      fb_wren <= 1'b1;
    end else begin
      fb_wren <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// tb/tb_pixel_fb_writer.sv - randomized and directed bench for pixel_fb_writer with a write-order scoreboard
module tb_pixel_fb_writer;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int WORDS = W * H;

  logic        clk = 0;
  logic        resetn = 0;
  logic        pix_valid = 0;
  logic        pix_ready;
  logic [7:0]  pix_x = 0;
  logic [6:0]  pix_y = 0;
  logic [8:0]  pix_colour = 0;
  logic        clear_req = 0;
  logic [8:0]  clear_colour = 0;
  logic        busy;
  logic [14:0] fb_addr;
  logic [8:0]  fb_data;
  logic        fb_wren;
  logic [7:0]  drop_count;

  pixel_fb_writer dut (
    .clk          (clk),
    .resetn       (resetn),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_colour   (pix_colour),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .busy         (busy),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .fb_wren      (fb_wren),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
    bit clr;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  up_edges = 0;
  bit  model_busy = 0;
  int  model_drop = 0;
  int  clr_writes = 0;
  int  px_writes = 0;
  int  px_mark = 0;
  int  px_first = -1;
  int  px_last = -1;
  int  stalls = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    if (!resetn) up_edges = 0;
    else up_edges = up_edges + 1;
  end

  // Reference model: every accepted on-screen pixel becomes one write two
  // cycles later at y*W+x; an accepted clear appends the whole screen sweep.
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (!resetn) begin
      exp_q.delete();
      model_busy = 0;
      model_drop = 0;
    end else begin
      if (fb_wren) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", int'(fb_addr), -1);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", int'(fb_addr), e.addr);
          chk("write_data", int'(fb_data), e.data);
          if (e.clr) begin
            clr_writes++;
            if (e.addr == WORDS - 1) model_busy = 0;
          end else begin
            chk("pixel_latency", cyc - e.cyc, 2);
            if (px_writes == px_mark) px_first = int'(fb_addr);
            px_last = int'(fb_addr);
            px_writes++;
          end
        end
      end
      chk("busy", int'(busy), int'(model_busy));
      chk("pix_ready", int'(pix_ready), int'(up_edges >= 1 && !model_busy));
      chk("drop_count", int'(drop_count), model_drop);
      if (pix_valid && pix_ready) begin
        if (int'(pix_x) < W && int'(pix_y) < H) begin
          exp_q.push_back('{addr: int'(pix_y) * W + int'(pix_x), data: int'(pix_colour), cyc: cyc, clr: 0});
        end else if (model_drop < 255) begin
          model_drop++;
        end
      end
      if (clear_req && !model_busy) begin
        model_busy = 1;
        for (int a = 0; a < WORDS; a++) begin
          exp_q.push_back('{addr: a, data: int'(clear_colour), cyc: cyc, clr: 1});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input int x, input int y, input int c);
    bit ok;
    ok = 0;
    pix_valid  = 1;
    pix_x      = 8'(x);
    pix_y      = 7'(y);
    pix_colour = 9'(c);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = pix_ready;
      if (!ok) stalls++;
      step();
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 20100 && !done; i++) begin
      step();
      if (!busy) done = 1;
    end
    chk(name, int'(done), 1);
  endtask

  initial begin
    int mark;
    bit hit;
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int mark;
    bit hit;
    // reset state
    #3;
    chk("rst_fb_wren", int'(fb_wren), 0);
    chk("rst_fb_addr", int'(fb_addr), 0);
    chk("rst_fb_data", int'(fb_data), 0);
    chk("rst_drop", int'(drop_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(pix_ready), 0);
    step();
    step();
    resetn = 1;
    #1;
    chk("ready_before_edge", int'(pix_ready), 0);
    step();
    chk("ready_after_edge", int'(pix_ready), 1);

    // single pixel, latency 2
    send_pix(19, 19, 9'h1C0);
    pix_valid = 0;
    chk("single_wren_k", int'(fb_wren), 0);
    step();
    chk("single_wren_k1", int'(fb_wren), 1);
    chk("single_addr", int'(fb_addr), 3059);
    chk("single_data", int'(fb_data), 9'h1C0);
    step();
    chk("single_wren_k2", int'(fb_wren), 0);

    // off-screen boundary pixels
    send_pix(160, 0, 1);
    send_pix(0, 120, 2);
    pix_valid = 0;
    repeat (3) step();
    chk("drop_two", int'(drop_count), 2);

    // 20x20 tile at grid (1,2), back to back
    px_mark = px_writes;
    stalls  = 0;
    for (int ty = 0; ty < 20; ty++)
      for (int tx = 0; tx < 20; tx++)
        send_pix(20 + tx, 40 + ty, $urandom_range(0, 511));
    pix_valid = 0;
    repeat (4) step();
    chk("tile_stalls", stalls, 0);
    chk("tile_count", px_writes - px_mark, 400);
    chk("tile_first", px_first, 6420);
    chk("tile_last", px_last, 9479);

    // random stream, on- and off-screen mixed
    for (int i = 0; i < 300; i++) begin
      pix_valid  = ($urandom_range(0, 2) != 0);
      pix_x      = 8'($urandom_range(0, 175));
      pix_y      = 7'($urandom_range(0, 127));
      pix_colour = 9'($urandom);
      step();
    end
    pix_valid = 0;
    repeat (4) step();

    // saturation
    for (int i = 0; i < 300; i++) send_pix(160 + (i % 96), $urandom_range(0, 127), i);
    pix_valid = 0;
    repeat (3) step();
    chk("drop_saturated", int'(drop_count), 255);

    // clear with pixels in flight; third pixel shares the clear edge
    mark = clr_writes;
    send_pix(5, 6, 9'h011);
    send_pix(159, 119, 9'h022);
    pix_valid = 1; pix_x = 8'd0; pix_y = 7'd0; pix_colour = 9'h033;
    clear_req = 1; clear_colour = 9'h000;
    @(negedge clk);
    chk("clear_edge_ready", int'(pix_ready), 1);
    step();
    clear_req = 0;
    pix_valid = 0;
    wait_idle("clear1_done");
    step();
    chk("clear1_writes", clr_writes - mark, WORDS);
    chk("clear1_ready_after", int'(pix_ready), 1);

    // second request during the sweep is ignored
    mark = clr_writes;
    clear_req = 1; clear_colour = 9'h0AA;
    step();
    clear_req = 0;
    repeat (100) step();
    clear_req = 1; clear_colour = 9'h155;
    step();
    clear_req = 0;
    wait_idle("clear2_done");
    step();
    chk("clear2_writes", clr_writes - mark, WORDS);

    // reset in the middle of a sweep
    clear_req = 1; clear_colour = 9'($urandom);
    step();
    clear_req = 0;
    hit = 0;
    for (int i = 0; i < 6000 && !hit; i++) begin
      step();
      if (fb_wren && fb_addr == 15'd5000) hit = 1;
    end
    chk("reached_addr_5000", int'(hit), 1);
    resetn = 0;
    #1;
    chk("midrst_wren", int'(fb_wren), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_drop", int'(drop_count), 0);
    chk("midrst_ready", int'(pix_ready), 0);
    step();
    resetn = 1;
    #1;
    chk("rel_ready_before", int'(pix_ready), 0);
    step();
    chk("rel_ready_after", int'(pix_ready), 1);

    for (int i = 0; i < 40; i++) send_pix($urandom_range(0, 170), $urandom_range(0, 125), $urandom);
    pix_valid = 0;
    repeat (5) step();
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_fb_writer.md
PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning pixel buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter SCREEN_W, default 160, meaning visible columns.
REQ-003 SHALL have parameter SCREEN_H, default 120, meaning visible rows.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port resetn, input, 1, reset: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port pix_valid, input, 1, meaning the upstream pixel is present.
REQ-007 SHALL have port pix_ready, output, 1, meaning the block accepts the pixel this cycle.
REQ-008 SHALL have port pix_x, input, 8, meaning pixel column.
REQ-009 SHALL have port pix_y, input, 7, meaning pixel row.
REQ-010 SHALL have port pix_colour, input, 9, meaning 3-3-3 RGB.
REQ-011 SHALL have port clear_req, input, 1, meaning a one-cycle screen-clear request.
REQ-012 SHALL have port clear_colour, input, 9, meaning fill colour, sampled with clear_req.
REQ-013 SHALL have port busy, output, 1, meaning a clear is pending or running.
REQ-014 SHALL have port fb_addr, output, 15, meaning framebuffer word address.
REQ-015 SHALL have port fb_data, output, 9, meaning framebuffer write data.
REQ-016 SHALL have port fb_wren, output, 1, meaning framebuffer write strobe, one word per cycle.
REQ-017 SHALL have port drop_count, output, 8, meaning saturating count of rejected off-screen pixels.

Function
REQ-018 Transfer SHALL occur on a rising edge with pix_valid and pix_ready both high; pix_valid without pix_ready holds upstream data.
REQ-019 pix_ready SHALL be high only in state IDLE with the FIFO not full; it is a registered/FIFO-count function, independent of pix_valid.
REQ-020 Accepted pixels with pix_x >= SCREEN_W or pix_y >= SCREEN_H SHALL be discarded and increment drop_count, saturating at 255.
REQ-021 In-range pixels SHALL be pushed to the FIFO; the head SHALL be popped every cycle the FIFO is non-empty and the state is IDLE or DRAIN.
REQ-022 fb_addr SHALL equal y*SCREEN_W + x, computed as (y<<7)+(y<<5)+x for the default, 15-bit result, max 19199.
REQ-023 fb_addr/fb_data/fb_wren SHALL be registered; a pixel accepted at edge k into an empty FIFO SHALL produce fb_wren high in the cycle after edge k+1 (latency 2).
REQ-024 Sustained throughput SHALL be one pixel per cycle; simultaneous push and pop SHALL leave occupancy unchanged; pixel order SHALL be preserved.
REQ-025 fb_wren SHALL be low in any cycle no write is issued; fb_addr/fb_data hold last values.
REQ-026 State machine SHALL have states IDLE, DRAIN, CLEAR.
REQ-027 IDLE -> DRAIN on clear_req high; clear_colour latched on that edge; a transfer on the same edge SHALL still be accepted and written before the clear.
REQ-028 DRAIN -> CLEAR when FIFO empty and no write outstanding; pix_ready low in DRAIN and CLEAR.
REQ-029 CLEAR SHALL write the latched colour to addresses 0..SCREEN_W*SCREEN_H-1 ascending, one per cycle, then return to IDLE after address 19199.
REQ-030 clear_req in DRAIN or CLEAR SHALL be ignored.
REQ-031 busy SHALL be high in DRAIN and CLEAR, low in IDLE.

Reset
REQ-032 resetn low SHALL immediately force state IDLE, FIFO empty, fb_wren 0, fb_addr 0, fb_data 0, drop_count 0, busy 0, pix_ready 0 while asserted.
REQ-033 Reset mid-clear or mid-drain SHALL abort without completing; buffered pixels are lost.
REQ-034 pix_ready SHALL rise on the first edge after resetn deasserts.

Structure
REQ-035 Package fb_pkg SHALL hold SCREEN_W, SCREEN_H, FB_WORDS (19200), COLOUR_W (9), FB_ADDR_W (15) and the state encoding.
REQ-036 The FIFO SHALL be a separate sub-module pixel_fifo (24-bit entries {x,y,colour}, push/pop/full/empty, registered count).
REQ-037 Address computation and the write stage SHALL live in pixel_fb_writer.

Verification
REQ-038 Single pixel x=19,y=19,colour=9'h1C0 into empty block -> fb_wren once, 2 cycles after accept, fb_addr=3059, fb_data=9'h1C0.
REQ-039 400 back-to-back pixels of a 20x20 tile at grid (1,2) with fb never stalled -> pix_ready stays high, 400 writes in order, first addr 6420, last 9479.
REQ-040 Pixels x=160,y=0 and x=0,y=120 -> no fb_wren, drop_count=2; 300 off-screen pixels -> drop_count=255.
REQ-041 clear_req with colour 9'h000 while 3 pixels buffered -> 3 pixel writes first, then 19200 writes addr 0..19199, busy high throughout, pix_ready low, then IDLE.
REQ-042 resetn pulsed low at clear address 5000 -> fb_wren 0 immediately, busy 0, drop_count 0, pix_ready high one edge after release.
REQ-043 Second clear_req during CLEAR -> ignored, exactly 19200 clear writes total.
